// File: rtl/divider_8by4_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// One quotient bit per cycle, MSB first; divide-by-zero short-circuits to DONE.
module divider_8by4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned PR_W  = DVS_W + 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DVD_W-1:0] dvd_sh;
  logic [DVD_W-1:0] q_sh;
  logic [DVS_W-1:0] dvs_r;
  // Only the low bits of the partial remainder are kept between steps:
  // after a step it is always below the divisor, so its top bit is zero.
  logic [DVS_W-1:0] pr;
  logic [CNT_W-1:0] cnt;

  logic [PR_W-1:0]  pr_shift;
  logic [DVS_W-1:0] pr_step;
  logic             q_bit;
  logic             last_step;
  logic             zero_div;
  logic             busy_nxt;
  logic             done_nxt;

  assign last_step = (cnt == CNT_W'(DVD_W - 1));
  assign zero_div  = (divisor == '0);

  // One restoring-division step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    pr_shift = {pr, dvd_sh[DVD_W-1]};
    q_bit    = (pr_shift >= {1'b0, dvs_r});
    pr_step  = pr_shift[DVS_W-1:0];
    if (q_bit) begin
      pr_step = DVS_W'(pr_shift - {1'b0, dvs_r});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = zero_div ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs follow the state being entered so they register in step with it.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == S_RUN) begin
      busy_nxt = 1'b1;
    end
    if (state_nxt == S_DONE) begin
      done_nxt = 1'b1;
    end
  end

  // Status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh      <= '0;
      dvs_r       <= '0;
      q_sh        <= '0;
      pr          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_sh <= dividend;
            dvs_r  <= divisor;
            q_sh   <= '0;
            pr     <= '0;
            cnt    <= '0;
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= '1;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          dvd_sh <= {dvd_sh[DVD_W-2:0], 1'b0};
          q_sh   <= {q_sh[DVD_W-2:0], q_bit};
          pr     <= pr_step;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            quotient    <= {q_sh[DVD_W-2:0], q_bit};
            remainder   <= pr_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Scoreboard bench for divider_8by4_seq: directed cases, protocol checks,
// mid-run reset and an exhaustive operand sweep against a reference model.
module tb_divider_8by4_seq;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests;
  int fails;
  int done_cnt;
  exp_t sb_q[$];

  divider_8by4_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  // Issue one division; called at a negedge with the DUT in IDLE.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez,
                         input bit check_hold, input bit inject);
    int busy_cyc;
    int cyc;
    exp_t e;
    e.q = eq;
    e.r = er;
    e.z = ez;
    sb_q.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    busy_cyc = 0;
    cyc      = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cyc++;
      if (inject && cyc == 2) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
      end
      if (inject && cyc == 4) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("busy_cycles", 32'(busy_cyc), (b == 4'd0) ? 32'd0 : 32'd8);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    if (check_hold) begin
      @(negedge clk);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'(eq));
      chk("hold_remainder", 32'(remainder), 32'(er));
      chk("hold_div_by_zero", 32'(div_by_zero), 32'(ez));
    end
  endtask

  initial begin
    int dc0;
    logic [7:0] mq;
    logic [3:0] mr;
    logic       mz;
    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    run_div(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 1'b1, 1'b0);
    run_div(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 1'b1, 1'b0);
    run_div(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 1'b1, 1'b0);
    run_div(8'd0,   4'd13, 8'd0,   4'd0, 1'b0, 1'b1, 1'b0);
    run_div(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 1'b1, 1'b0);
    run_div(8'd13,  4'd0,  8'hFF,  4'hF, 1'b1, 1'b1, 1'b0);
    run_div(8'd9,   4'd3,  8'd3,   4'd0, 1'b0, 1'b1, 1'b0);
    // Start re-asserted during RUN must be ignored.
    run_div(8'd100, 4'd6,  8'd16,  4'd4, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    // Reset in RUN cycle 4 aborts without a done pulse.
    dc0      = done_cnt;
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1, 1'b0);

    // Exhaustive sweep against the reference model.
    dc0 = done_cnt;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 8'hFF;
          mr = 4'hF;
          mz = 1'b1;
        end else begin
          mq = 8'(a / b);
          mr = 4'(a % b);
          mz = 1'b0;
        end
        run_div(8'(a), 4'(b), mq, mr, mz, 1'b0, 1'b0);
      end
    end
    chk("sweep_done_count", 32'(done_cnt - dc0), 32'd4096);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
